// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and default event indices for the sound-effect sequencer.
package sfx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } sfx_state_e;

    localparam int EV_SHOT       = 0;
    localparam int EV_ENEMY_DEAD = 1;
    localparam int EV_PLAYER_HIT = 2;
    localparam int EV_LEVEL_UP   = 3;

endpackage

// File: rtl/sfx_prio_enc.sv
// sfx_prio_enc: highest-set-bit encoder returning valid flag and index.
module sfx_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = 0; i < N; i++)
            if (req[i]) idx = IW'(i);
    end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: priority-arbitrated, pre-emptive multi-note sound-effect player.
// Define SFX_PENDING_EN to queue lower-priority requests instead of dropping them.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int NUM_EVENTS  = 4,
    parameter int KEY_W       = 4,
    parameter int NOTE_CNT    = 3,
    parameter int NOTE_FRAMES = 4
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic [NUM_EVENTS-1:0]               event_req,
    input  logic [NUM_EVENTS-1:0][KEY_W-1:0]    cfg_base_key,
    input  logic [NUM_EVENTS-1:0][KEY_W-1:0]    cfg_step,
    output logic [KEY_W-1:0]                    sound_key,
    output logic                                sound_on,
    output logic [$clog2(NUM_EVENTS)-1:0]       active_event,
    output logic                                busy
);

    localparam int IW = $clog2(NUM_EVENTS);
    localparam int NW = (NOTE_CNT > 1) ? $clog2(NOTE_CNT) : 1;
    localparam int FW = $clog2(NOTE_FRAMES + 1);

    sfx_state_e            state_q, state_n;
    logic [IW-1:0]         idx_q, idx_n;
    logic [KEY_W-1:0]      key_q, key_n;
    logic [NW-1:0]         note_q, note_n;
    logic [FW-1:0]         cnt_q, cnt_n;
    logic [NUM_EVENTS-1:0] pending, eff;
    logic                  req_v, eff_v, start;
    logic [IW-1:0]         req_idx, eff_idx, st_idx;

    assign eff = event_req | pending;

    sfx_prio_enc #(.N(NUM_EVENTS), .IW(IW)) u_req_enc (
        .req   (event_req),
        .valid (req_v),
        .idx   (req_idx)
    );

    sfx_prio_enc #(.N(NUM_EVENTS), .IW(IW)) u_eff_enc (
        .req   (eff),
        .valid (eff_v),
        .idx   (eff_idx)
    );

`ifdef SFX_PENDING_EN
    // Every request that does not start an effect this cycle is remembered.
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) pending <= '0;
        else         pending <= (pending | event_req) & ~(start ? (NUM_EVENTS'(1) << st_idx) : '0);
`else
    assign pending = '0;
`endif

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        key_n   = key_q;
        note_n  = note_q;
        cnt_n   = cnt_q;
        start   = 1'b0;
        st_idx  = eff_idx;
        if (state_q != S_IDLE && req_v && req_idx >= idx_q) begin
            start  = 1'b1;
            st_idx = req_idx;
        end else if (state_q == S_IDLE) begin
            start = eff_v;
        end else if (state_q == S_GAP && startOfFrame) begin
            start = eff_v;
            if (!eff_v) begin
                state_n = S_IDLE;
                idx_n   = '0;
            end
        end else if (state_q == S_PLAY && startOfFrame) begin
            if (cnt_q == FW'(NOTE_FRAMES - 1)) begin
                cnt_n = '0;
                if (note_q == NW'(NOTE_CNT - 1)) begin
                    state_n = S_GAP;
                    key_n   = '0;
                end else begin
                    note_n = note_q + 1'b1;
                    key_n  = key_q + cfg_step[idx_q];
                end
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
        // A start overrides any frame bookkeeping on the same cycle.
        if (start) begin
            state_n = S_PLAY;
            idx_n   = st_idx;
            key_n   = cfg_base_key[st_idx];
            note_n  = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            note_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            key_q   <= key_n;
            note_q  <= note_n;
            cnt_q   <= cnt_n;
        end

    assign sound_key    = key_q;
    assign sound_on     = state_q == S_PLAY;
    assign busy         = state_q != S_IDLE;
    assign active_event = idx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: table-driven and directed checks of the sound-effect sequencer.
module tb_sfx_sequencer;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             startOfFrame = 1'b0;
    logic [3:0]       event_req = '0;
    logic [3:0][3:0]  cfg_base_key;
    logic [3:0][3:0]  cfg_step;
    logic [3:0]       sound_key;
    logic             sound_on;
    logic [1:0]       active_event;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] req;
        logic       sof;
        logic       on;
        logic [3:0] key;
        logic [1:0] ev;
        logic       busy;
    } vec_t;

    vec_t vec[32];
    int   nv = 0;

    sfx_sequencer #(
        .NUM_EVENTS  (4),
        .KEY_W       (4),
        .NOTE_CNT    (3),
        .NOTE_FRAMES (4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .event_req    (event_req),
        .cfg_base_key (cfg_base_key),
        .cfg_step     (cfg_step),
        .sound_key    (sound_key),
        .sound_on     (sound_on),
        .active_event (active_event),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic on, input logic [3:0] key,
                         input logic [1:0] ev, input logic bz);
        n_tests++;
        if (sound_on !== on || sound_key !== key || active_event !== ev || busy !== bz) begin
            n_fail++;
            $display("FAIL %s: got on=%0b key=%0d ev=%0d busy=%0b, expected on=%0b key=%0d ev=%0d busy=%0b",
                     name, sound_on, sound_key, active_event, busy, on, key, ev, bz);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic sof, input logic on,
                       input logic [3:0] key, input logic [1:0] ev, input logic bz);
        vec[nv] = '{req, sof, on, key, ev, bz};
        nv++;
    endtask

    task automatic apply(input logic [3:0] req, input logic sof);
        event_req    = req;
        startOfFrame = sof;
        tick();
        event_req    = '0;
        startOfFrame = 1'b0;
    endtask

    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) apply(4'b0000, 1'b1);
    endtask

    initial begin
        cfg_base_key = {4'd5, 4'd9, 4'd14, 4'd3};
        cfg_step     = {4'hF, 4'd1, 4'd3, 4'd2};

        // Event 0: keys 3,5,7 for 4 frames each, one gap frame, then idle.
        add(4'b0001, 1'b0, 1'b1, 4'd3, 2'd0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            for (int f = 0; f < 3; f++) add(4'b0000, 1'b1, 1'b1, 4'(3 + 2 * j), 2'd0, 1'b1);
            add(4'b0000, 1'b0, 1'b1, 4'(3 + 2 * j), 2'd0, 1'b1);
            if (j < 2) add(4'b0000, 1'b1, 1'b1, 4'(5 + 2 * j), 2'd0, 1'b1);
            else       add(4'b0000, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1);
        end
        add(4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        add(4'b0000, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);

        #2;
        check("reset_async", 1'b0, 4'd0, 2'd0, 1'b0);
        tick();
        resetN = 1'b1;
        tick();
        check("reset_idle", 1'b0, 4'd0, 2'd0, 1'b0);

        for (int i = 0; i < nv; i++) begin
            apply(vec[i].req, vec[i].sof);
            check($sformatf("vec%0d", i), vec[i].on, vec[i].key, vec[i].ev, vec[i].busy);
        end

        // Higher-priority event pre-empts event 0 mid-note.
        apply(4'b0001, 1'b0);
        check("ev0_start", 1'b1, 4'd3, 2'd0, 1'b1);
        sofs(1);
        apply(4'b0100, 1'b0);
        check("preempt_ev2", 1'b1, 4'd9, 2'd2, 1'b1);
        sofs(3);
        check("preempt_note0_hold", 1'b1, 4'd9, 2'd2, 1'b1);
        sofs(1);
        check("preempt_note1", 1'b1, 4'd10, 2'd2, 1'b1);
        sofs(8);
        check("preempt_gap", 1'b0, 4'd0, 2'd2, 1'b1);
        sofs(1);
        check("preempt_idle", 1'b0, 4'd0, 2'd0, 1'b0);

        // Simultaneous requests 3 and 1, coincident with a frame pulse.
        apply(4'b1010, 1'b1);
        check("simul_ev3", 1'b1, 4'd5, 2'd3, 1'b1);
        sofs(4);
        check("ev3_neg_step", 1'b1, 4'd4, 2'd3, 1'b1);
        sofs(8);
        check("ev3_gap", 1'b0, 4'd0, 2'd3, 1'b1);
        sofs(1);
`ifdef SFX_PENDING_EN
        check("pending_ev1", 1'b1, 4'd14, 2'd1, 1'b1);
`else
        check("dropped_idle", 1'b0, 4'd0, 2'd0, 1'b0);
        apply(4'b0010, 1'b0);
        check("ev1_start", 1'b1, 4'd14, 2'd1, 1'b1);
`endif

        // Key wrap: 14 -> 1 -> 4.
        sofs(4);
        check("wrap_note1", 1'b1, 4'd1, 2'd1, 1'b1);
        sofs(4);
        check("wrap_note2", 1'b1, 4'd4, 2'd1, 1'b1);

        // Same-index request restarts the effect from note 0.
        sofs(1);
        apply(4'b0010, 1'b0);
        check("restart_ev1", 1'b1, 4'd14, 2'd1, 1'b1);
        apply(4'b0001, 1'b0);
        check("lower_no_preempt", 1'b1, 4'd14, 2'd1, 1'b1);
        sofs(4);
        check("restart_note1", 1'b1, 4'd1, 2'd1, 1'b1);

        // Asynchronous reset mid-effect silences at once and clears pending.
        #2;
        resetN = 1'b0;
        #1;
        check("midplay_reset", 1'b0, 4'd0, 2'd0, 1'b0);
        tick();
        resetN = 1'b1;
        tick();
        tick();
        check("post_reset_idle", 1'b0, 4'd0, 2'd0, 1'b0);
        sofs(2);
        check("post_reset_no_pending", 1'b0, 4'd0, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
